// File: rtl/vga_fb_pkg.sv
// Shared constants, FSM encoding and address helper for the framebuffer arbiter.
//   FB_W/FB_H/FB_SIZE/FB_AW : framebuffer geometry (160x120, 15-bit address)
//   *_DEF                   : default visible-window bounds in timing-generator counts
//   arb_state_e             : arbiter FSM states
//   xy_to_addr(y,x)         : row-major pixel address, y*160+x built from shifts
package vga_fb_pkg;

  localparam int unsigned FB_W    = 160;
  localparam int unsigned FB_H    = 120;
  localparam int unsigned FB_SIZE = FB_W * FB_H;
  localparam int unsigned FB_AW   = 15;

  localparam int unsigned H_START_DEF = 400;
  localparam int unsigned H_END_DEF   = 560;
  localparam int unsigned V_START_DEF = 221;
  localparam int unsigned V_END_DEF   = 341;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  // 160 = 128 + 32, so the multiply collapses to two shifts and an add.
  function automatic logic [FB_AW-1:0] xy_to_addr(input logic [6:0] y, input logic [7:0] x);
    logic [FB_AW-1:0] yy;
    yy = {8'd0, y};
    return (yy << 7) + (yy << 5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Small synchronous FIFO buffering accepted pixel writes until a free RAM cycle.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   flush      : discard all entries on the next edge (takes priority over push/pop)
//   push, din  : write an entry (ignored when full)
//   pop, dout  : dout shows the head combinationally; pop advances it (ignored when empty)
//   full/empty : occupancy flags
module fb_write_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit tells a full FIFO apart from an empty one.
  logic [PW:0] wptr_q, wptr_d;
  logic [PW:0] rptr_q, rptr_d;
  logic        do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q[PW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch, buffered pixel writes and a
// full-screen clear engine share one synchronous RAM port.
//   clk_25, reset_n          : pixel clock, asynchronous active-low reset
//   h_count, v_count, bright : timing generator counts and registered visible flag
//   wr_valid/wr_ready, wr_x, wr_y, wr_data, wr_drop : pixel write requester
//   clear_req, clear_color, clear_busy, clear_done  : full-screen clear control
//   mem_addr, mem_we, mem_wdata, mem_rdata           : framebuffer RAM port
//   pixel_out                : pixel to the DAC (0 outside the visible area)
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_START    = H_START_DEF,
  parameter int unsigned H_END      = H_END_DEF,
  parameter int unsigned V_START    = V_START_DEF,
  parameter int unsigned V_END      = V_END_DEF
) (
  input  logic             clk_25,
  input  logic             reset_n,
  input  logic [9:0]       h_count,
  input  logic [9:0]       v_count,
  input  logic             bright,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_x,
  input  logic [6:0]       wr_y,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_drop,
  input  logic             clear_req,
  input  logic [PIX_W-1:0] clear_color,
  output logic             clear_busy,
  output logic             clear_done,
  output logic [FB_AW-1:0] mem_addr,
  output logic             mem_we,
  output logic [PIX_W-1:0] mem_wdata,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic [PIX_W-1:0] pixel_out
);

  localparam int unsigned ENT_W = FB_AW + PIX_W;

  arb_state_e       state_q, state_d;
  logic [FB_AW-1:0] clr_addr_q, clr_addr_d;
  logic [PIX_W-1:0] clr_color_q, clr_color_d;
  logic             clr_done_q, clr_done_d;
  logic             wr_drop_q, wr_drop_d;

  logic             slot;
  logic [6:0]       dy;
  logic [7:0]       dx;
  logic [FB_AW-1:0] disp_addr;
  logic             in_range, accept;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [ENT_W-1:0] fifo_din, fifo_dout;

  // Display slot: the RAM port belongs to the fetch path for every visible pixel.
  assign slot = (h_count >= 10'(H_START)) && (h_count < 10'(H_END)) &&
                (v_count >= 10'(V_START)) && (v_count < 10'(V_END));
  // Offsets only matter inside the slot, where they fit 8 and 7 bits.
  assign dx        = 8'(h_count - 10'(H_START));
  assign dy        = 7'(v_count - 10'(V_START));
  assign disp_addr = xy_to_addr(dy, dx);

  assign pixel_out = bright ? mem_rdata : '0;

  assign wr_ready  = !fifo_full && (state_q == IDLE) && !clear_req;
  assign accept    = wr_valid && wr_ready;
  assign in_range  = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
  assign fifo_push = accept && in_range;
  assign fifo_din  = {xy_to_addr(wr_y, wr_x), wr_data};
  assign wr_drop_d = accept && !in_range;

  assign clear_busy = (state_q == CLEAR);
  assign clear_done = clr_done_q;
  assign wr_drop    = wr_drop_q;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    clr_done_d  = 1'b0;
    fifo_flush  = 1'b0;
    fifo_pop    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    if (state_q == IDLE && clear_req) begin
      // Queued writes would be overwritten by the clear, so drop them now.
      state_d     = CLEAR;
      clr_addr_d  = '0;
      clr_color_d = clear_color;
      fifo_flush  = 1'b1;
    end

    if (slot) begin
      mem_addr = disp_addr;
    end else if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr_q;
      mem_wdata = clr_color_q;
      if (clr_addr_q == FB_AW'(FB_SIZE - 1)) begin
        state_d    = IDLE;
        clr_addr_d = '0;
        clr_done_d = 1'b1;
      end else begin
        clr_addr_d = clr_addr_q + 1'b1;
      end
    end else if (!fifo_empty && !clear_req) begin
      // A clear starting this cycle flushes the FIFO, so its head is not written.
      fifo_pop  = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = fifo_dout[ENT_W-1:PIX_W];
      mem_wdata = fifo_dout[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      clr_done_q  <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      clr_done_q  <= clr_done_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  fb_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk_25),
    .rst_n (reset_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  logic        clk_25 = 1'b0;
  logic        reset_n;
  logic [9:0]  h_count, v_count;
  logic        bright = 1'b0;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [7:0]  wr_data;
  logic        wr_drop;
  logic        clear_req;
  logic [7:0]  clear_color;
  logic        clear_busy, clear_done;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  pixel_out;

  int checks   = 0;
  int failures = 0;

  // Timing model: counts sweep [hlo,hhi] x [vlo,vhi], chosen per test.
  int hlo, hhi, vlo, vhi, h, v;

  logic [7:0] ram [19200];

  typedef struct { int addr; int data; } wr_t;

  always #5 clk_25 = ~clk_25;

  vga_fb_arbiter dut (
    .clk_25      (clk_25),
    .reset_n     (reset_n),
    .h_count     (h_count),
    .v_count     (v_count),
    .bright      (bright),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
    .wr_drop     (wr_drop),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pixel_out   (pixel_out)
  );

  function automatic bit in_win(int hh, int vv);
    return (hh >= 400) && (hh < 560) && (vv >= 221) && (vv < 341);
  endfunction

  // Environment: synchronous RAM with 1-cycle read latency, and the timing
  // generator's registered visible flag.
  always @(posedge clk_25) begin
    if (mem_we && mem_addr < 15'd19200) ram[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_addr < 15'd19200) ? ram[mem_addr] : 8'h00;
    bright    <= in_win(int'(h_count), int'(v_count));
  end

  task automatic settle();
    #2;
  endtask

  task automatic next();
    @(posedge clk_25);
    #1;
  endtask

  task automatic advance();
    h++;
    if (h > hhi) begin
      h = hlo;
      v++;
      if (v > vhi) v = vlo;
    end
  endtask

  task automatic put_counts();
    h_count = 10'(h);
    v_count = 10'(v);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_valid = 1'b0; clear_req = 1'b0;
    wr_x = 8'd0; wr_y = 7'd0; wr_data = 8'd0; clear_color = 8'd0;
    h = 0; v = 0; put_counts();
    settle();
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
    checks++; if (clear_busy !== 1'b0) begin failures++; $display("FAIL reset_clear_busy got=%0b exp=0", clear_busy); end
    checks++; if (clear_done !== 1'b0) begin failures++; $display("FAIL reset_clear_done got=%0b exp=0", clear_done); end
    checks++; if (wr_drop !== 1'b0) begin failures++; $display("FAIL reset_wr_drop got=%0b exp=0", wr_drop); end
    repeat (3) next();
    settle();
    reset_n = 1'b1;
    next();
    settle();
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%0b exp=1", wr_ready); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL post_reset_mem_we got=%0b exp=0", mem_we); end
    $display("test_reset done");
    next();
  endtask

  task automatic test_display_scan();
    int ea;
    logic [7:0] prev_pix, exp_pix;
    hlo = 395; hhi = 564; vlo = 219; vhi = 342;
    h = hlo; v = vlo;
    prev_pix = 8'h00;
    for (int n = 0; n < 124 * 170; n++) begin
      put_counts();
      settle();
      exp_pix = bright ? prev_pix : 8'h00;
      checks++; if (pixel_out !== exp_pix) begin failures++; $display("FAIL scan_pixel h=%0d v=%0d got=%02h exp=%02h", h, v, pixel_out, exp_pix); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL scan_mem_we h=%0d v=%0d got=%0b exp=0", h, v, mem_we); end
      if (in_win(h, v)) begin
        ea = (v - 221) * 160 + (h - 400);
        checks++; if (int'(mem_addr) != ea) begin failures++; $display("FAIL scan_addr h=%0d v=%0d got=%0d exp=%0d", h, v, mem_addr, ea); end
        if (h == 400 && v == 221) $display("scan corner first addr=%0d exp=0", mem_addr);
        if (h == 559 && v == 340) $display("scan corner last addr=%0d exp=19199", mem_addr);
        prev_pix = ram[ea];
      end else begin
        prev_pix = 8'h00;
      end
      next();
      advance();
    end
    $display("test_display_scan done");
  endtask

  task automatic test_single_write();
    h = 380; v = 230; put_counts();
    wr_x = 8'd5; wr_y = 7'd2; wr_data = 8'hA5; wr_valid = 1'b1;
    settle();
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0b exp=1", wr_ready); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0b exp=0", mem_we); end
    next();
    wr_valid = 1'b0;
    settle();
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL single_we got=%0b exp=1", mem_we); end
    checks++; if (int'(mem_addr) != 2 * 160 + 5) begin failures++; $display("FAIL single_addr got=%0d exp=325", mem_addr); end
    checks++; if (mem_wdata !== 8'hA5) begin failures++; $display("FAIL single_data got=%02h exp=a5", mem_wdata); end
    next();
    settle();
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL single_after_we got=%0b exp=0", mem_we); end
    $display("single write x=5 y=2 data=a5 addr=%0d", 325);
    next();
  endtask

  task automatic test_back_to_back();
    wr_t q[$];
    wr_t e;
    int x, y, d;
    bit exp_ready;
    h = 450; v = 250; put_counts();
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom_range(159, 0)); y = int'($urandom_range(119, 0)); d = int'($urandom_range(255, 0));
      wr_x = 8'(x); wr_y = 7'(y); wr_data = 8'(d); wr_valid = 1'b1;
      settle();
      exp_ready = (q.size() < 4);
      checks++; if (wr_ready !== exp_ready) begin failures++; $display("FAIL b2b_ready i=%0d got=%0b exp=%0b", i, wr_ready, exp_ready); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL b2b_slot_we i=%0d got=%0b exp=0", i, mem_we); end
      if (exp_ready) begin e.addr = y * 160 + x; e.data = d; q.push_back(e); end
      $display("b2b write i=%0d x=%0d y=%0d data=%02h ready=%0b", i, x, y, d, wr_ready);
      next();
    end
    wr_valid = 1'b0;
    h = 560; put_counts();
    for (int i = 0; i < 6; i++) begin
      settle();
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++; if (mem_we !== 1'b1 || int'(mem_addr) != e.addr || int'(mem_wdata) != e.data) begin
          failures++; $display("FAIL b2b_drain i=%0d got we=%0b addr=%0d data=%02h exp we=1 addr=%0d data=%02h", i, mem_we, mem_addr, mem_wdata, e.addr, e.data);
        end
      end else begin
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL b2b_extra_we i=%0d got=%0b exp=0", i, mem_we); end
      end
      next();
    end
  endtask

  task automatic test_drop();
    int bx[2] = '{160, 0};
    int by[2] = '{0, 120};
    h = 380; v = 230; put_counts();
    for (int i = 0; i < 2; i++) begin
      wr_x = 8'(bx[i]); wr_y = 7'(by[i]); wr_data = 8'h77; wr_valid = 1'b1;
      settle();
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL drop_ready i=%0d got=%0b exp=1", i, wr_ready); end
      next();
      wr_valid = 1'b0;
      settle();
      checks++; if (wr_drop !== 1'b1) begin failures++; $display("FAIL drop_pulse i=%0d got=%0b exp=1", i, wr_drop); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL drop_we i=%0d got=%0b exp=0", i, mem_we); end
      next();
      settle();
      checks++; if (wr_drop !== 1'b0) begin failures++; $display("FAIL drop_pulse_end i=%0d got=%0b exp=0", i, wr_drop); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL drop_we2 i=%0d got=%0b exp=0", i, mem_we); end
      $display("drop write x=%0d y=%0d", bx[i], by[i]);
      next();
    end
  endtask

  task automatic test_random_traffic();
    wr_t q[$];
    wr_t e;
    int x, y, d, writes;
    bit exp_ready, drop_pend, acc;
    hlo = 380; hhi = 679; vlo = 335; vhi = 345;
    h = hlo; v = vlo; drop_pend = 1'b0; writes = 0;
    for (int n = 0; n < 3000; n++) begin
      put_counts();
      x = int'($urandom_range(170, 0)); y = int'($urandom_range(125, 0)); d = int'($urandom_range(255, 0));
      wr_x = 8'(x); wr_y = 7'(y); wr_data = 8'(d);
      wr_valid = ($urandom_range(2, 0) != 0);
      settle();
      exp_ready = (q.size() < 4);
      checks++; if (wr_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, wr_ready, exp_ready); end
      checks++; if (wr_drop !== drop_pend) begin failures++; $display("FAIL rnd_drop n=%0d got=%0b exp=%0b", n, wr_drop, drop_pend); end
      if (in_win(h, v)) begin
        checks++; if (mem_we !== 1'b0 || int'(mem_addr) != (v - 221) * 160 + (h - 400)) begin
          failures++; $display("FAIL rnd_slot n=%0d got we=%0b addr=%0d exp we=0 addr=%0d", n, mem_we, mem_addr, (v - 221) * 160 + (h - 400));
        end
      end else if (q.size() > 0) begin
        e = q.pop_front();
        writes++;
        checks++; if (mem_we !== 1'b1 || int'(mem_addr) != e.addr || int'(mem_wdata) != e.data) begin
          failures++; $display("FAIL rnd_write n=%0d got we=%0b addr=%0d data=%02h exp we=1 addr=%0d data=%02h", n, mem_we, mem_addr, mem_wdata, e.addr, e.data);
        end
      end else begin
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rnd_idle_we n=%0d got=%0b exp=0", n, mem_we); end
      end
      acc = wr_valid && exp_ready;
      drop_pend = acc && !(x < 160 && y < 120);
      if (acc && x < 160 && y < 120) begin e.addr = y * 160 + x; e.data = d; q.push_back(e); end
      next();
      advance();
    end
    wr_valid = 1'b0;
    $display("random traffic: %0d RAM writes checked, %0d still queued", writes, q.size());
    // Let the queue drain in blanking so the next test starts empty.
    h = 380; v = 230; put_counts();
    repeat (6) next();
  endtask

  task automatic test_clear();
    bit seen [19200];
    int count;
    bit done;
    hlo = 380; hhi = 899; vlo = 219; vhi = 342;
    h = 450; v = 250; put_counts();
    for (int i = 0; i < 2; i++) begin
      wr_x = 8'(i); wr_y = 7'd0; wr_data = 8'h11; wr_valid = 1'b1;
      settle();
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL clr_queue_ready i=%0d got=%0b exp=1", i, wr_ready); end
      next();
    end
    clear_req = 1'b1; clear_color = 8'h3C; wr_valid = 1'b1;
    settle();
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL clr_refuse_write got=%0b exp=0", wr_ready); end
    next();
    clear_req = 1'b0; clear_color = 8'hC3; wr_valid = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    count = 0; done = 1'b0;
    for (int n = 0; n < 40000 && !done; n++) begin
      advance(); put_counts();
      settle();
      if (mem_we === 1'b1) begin
        checks++; if (in_win(h, v) || mem_wdata !== 8'h3C || mem_addr >= 15'd19200 || seen[mem_addr]) begin
          failures++; $display("FAIL clr_write n=%0d h=%0d v=%0d got addr=%0d data=%02h exp unique addr<19200 data=3c outside slot", n, h, v, mem_addr, mem_wdata);
        end else seen[mem_addr] = 1'b1;
        count++;
      end
      if (clear_done === 1'b1) begin
        done = 1'b1;
        checks++; if (clear_busy !== 1'b0) begin failures++; $display("FAIL clr_busy_at_done got=%0b exp=0", clear_busy); end
      end else begin
        checks++; if (clear_busy !== 1'b1 || wr_ready !== 1'b0) begin failures++; $display("FAIL clr_busy n=%0d got busy=%0b ready=%0b exp busy=1 ready=0", n, clear_busy, wr_ready); end
      end
      next();
    end
    checks++; if (!done) begin failures++; $display("FAIL clr_timeout got=no_done exp=clear_done within 40000 cycles"); end
    checks++; if (count != 19200) begin failures++; $display("FAIL clr_count got=%0d exp=19200", count); end
    $display("clear color=3c writes=%0d done=%0b", count, done);
    for (int i = 0; i < 4; i++) begin
      advance(); put_counts();
      settle();
      checks++; if (clear_done !== 1'b0) begin failures++; $display("FAIL clr_done_width i=%0d got=%0b exp=0", i, clear_done); end
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL clr_ready_restored i=%0d got=%0b exp=1", i, wr_ready); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL clr_flushed i=%0d got we=%0b exp=0", i, mem_we); end
      next();
    end
  endtask

  task automatic test_reset_mid_clear();
    hlo = 380; hhi = 899; vlo = 219; vhi = 342;
    h = 380; v = 230; put_counts();
    clear_req = 1'b1; clear_color = 8'h55;
    next();
    clear_req = 1'b0;
    for (int n = 0; n < 1000; n++) begin advance(); put_counts(); next(); end
    settle();
    checks++; if (clear_busy !== 1'b1) begin failures++; $display("FAIL rmc_busy_before got=%0b exp=1", clear_busy); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (clear_busy !== 1'b0) begin failures++; $display("FAIL rmc_busy_abort got=%0b exp=0", clear_busy); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rmc_we_abort got=%0b exp=0", mem_we); end
    for (int i = 0; i < 3; i++) begin
      next(); advance(); put_counts(); settle();
      checks++; if (clear_done !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rmc_in_reset i=%0d got done=%0b we=%0b exp 0 0", i, clear_done, mem_we); end
    end
    reset_n = 1'b1;
    next();
    h = 380; v = 230;
    for (int i = 0; i < 40; i++) begin
      put_counts(); settle();
      checks++; if (clear_done !== 1'b0 || clear_busy !== 1'b0 || wr_ready !== 1'b1 || mem_we !== 1'b0) begin
        failures++; $display("FAIL rmc_after i=%0d got done=%0b busy=%0b ready=%0b we=%0b exp 0 0 1 0", i, clear_done, clear_busy, wr_ready, mem_we);
      end
      next(); h++;
    end
    $display("reset mid-clear: aborted and idle");
  endtask

  initial begin
    foreach (ram[i]) ram[i] = 8'($urandom_range(255, 0));
    test_reset();
    test_display_scan();
    test_single_write();
    test_back_to_back();
    test_drop();
    test_random_traffic();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
